// File: rtl/display_update_ctrl.sv
// Paces pitch results onto the seven-segment driver with a minimum on-screen hold, clamping and silence blanking.
// Latency: an accepted result appears on num_to_display/note/disp_blank/upd_pulse one cycle after its transfer edge.
// Backpressure: res_ready is low only while a freshly shown result is being held; optional macro DISP_NOTE_STABLE_EN.
module display_update_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
    parameter int unsigned MAX_NUM        = 999
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [9:0] res_num,
    input  logic [2:0] res_note,
    output logic [9:0] num_to_display,
    output logic [2:0] note,
    output logic       disp_blank,
    output logic       upd_pulse
);

    // Both counters share one width; TIMEOUT_CYCLES is the larger bound.
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SIL_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]    MAX_V     = 10'(MAX_NUM);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_HOLD  = 2'd1,
        ST_OPEN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  hold_q, hold_d;
    logic [CW-1:0]  sil_q, sil_d;
    logic [9:0]     num_q, num_d;
    logic [2:0]     note_q, note_d;
    logic           blank_q, blank_d;
    logic           upd_q, upd_d;

    logic           xfer;
    logic           accept;
    logic           show;
    logic [9:0]     num_clamped;
    logic [CW-1:0]  sil_next;

    // Ready is a pure decode of the registered state, so it never depends on res_valid.
    assign res_ready   = (state_q != ST_HOLD);
    assign xfer        = res_valid && res_ready;
    // Notes 6/7 still complete the handshake but are otherwise ignored.
    assign accept      = xfer && (res_note < 3'd6);
    assign num_clamped = (res_num > MAX_V) ? MAX_V : res_num;
    assign sil_next    = (sil_q == SIL_LAST) ? sil_q : sil_q + CW'(1);

`ifdef DISP_NOTE_STABLE_EN
    // Last accepted note; a note change is shown only when it repeats.
    logic [2:0] cand_q, cand_d;

    assign show = accept && ((state_q == ST_BLANK) || (res_note == note_q) || (res_note == cand_q));

    // Candidate register remembers the note of the previous accepted result.
    always_comb begin
        cand_d = cand_q;
        if (accept) begin
            cand_d = res_note;
        end
    end

    // Candidate register update with synchronous reset.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            cand_q <= 3'd0;
        end else begin
            cand_q <= cand_d;
        end
    end
`else
    assign show = accept;
`endif

    // Next-state, counter and output-register logic; an accepted transfer overrides a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sil_d   = sil_q;
        num_d   = num_q;
        note_d  = note_q;
        blank_d = blank_q;
        upd_d   = 1'b0;

        case (state_q)
            ST_BLANK: begin
                hold_d = '0;
                sil_d  = '0;
            end
            ST_HOLD: begin
                hold_d = hold_q + CW'(1);
                sil_d  = sil_next;
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                sil_d = sil_next;
                if (sil_q == SIL_LAST) begin
                    state_d = ST_BLANK;
                    blank_d = 1'b1;
                    sil_d   = '0;
                end
            end
            default: begin
                state_d = ST_BLANK;
                blank_d = 1'b1;
            end
        endcase

        if (accept) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            sil_d   = '0;
            blank_d = blank_q;
        end

        if (show) begin
            num_d   = num_clamped;
            note_d  = res_note;
            blank_d = 1'b0;
            upd_d   = 1'b1;
        end
    end

    // State, counters and display registers with synchronous active-low reset.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            hold_q  <= '0;
            sil_q   <= '0;
            num_q   <= 10'd0;
            note_q  <= 3'd0;
            blank_q <= 1'b1;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sil_q   <= sil_d;
            num_q   <= num_d;
            note_q  <= note_d;
            blank_q <= blank_d;
            upd_q   <= upd_d;
        end
    end

    assign num_to_display = num_q;
    assign note           = note_q;
    assign disp_blank     = blank_q;
    assign upd_pulse      = upd_q;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed bench for display_update_ctrl with HOLD_CYCLES=8, TIMEOUT_CYCLES=40.
// Expected display values are queued when a showing transfer is driven and popped on each upd_pulse.
// Inputs are driven and outputs sampled on the falling edge of clk_100.
module tb_display_update_ctrl;

    localparam int HOLD = 8;
    localparam int TMO  = 40;

    typedef struct packed {
        logic [9:0] num;
        logic [2:0] note;
    } exp_t;

    logic       clk_100;
    logic       rst_n;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_num;
    logic [2:0] res_note;
    logic [9:0] num_to_display;
    logic [2:0] note;
    logic       disp_blank;
    logic       upd_pulse;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    int   pulse_cyc[$];

    display_update_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .MAX_NUM       (999)
    ) dut (
        .clk_100       (clk_100),
        .rst_n         (rst_n),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_num       (res_num),
        .res_note      (res_note),
        .num_to_display(num_to_display),
        .note          (note),
        .disp_blank    (disp_blank),
        .upd_pulse     (upd_pulse)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every upd_pulse must match the oldest queued expectation.
    always @(negedge clk_100) begin
        if (upd_pulse === 1'b1) begin
            pulse_cyc.push_back(cyc);
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_pulse observed=%0d expected=none", num_to_display);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_num", 32'(num_to_display), 32'(e.num));
                chk("sb_note", 32'(note), 32'(e.note));
            end
        end
    end

    // Wait for ready, present one result for a single cycle; queue it if it should be shown.
    task automatic send(input logic [9:0] n, input logic [2:0] nt, input bit show, input logic [9:0] expn);
        int w;
        w = 0;
        while (res_ready !== 1'b1 && w < 100) begin
            @(negedge clk_100);
            w++;
        end
        chk("send_ready_wait_ok", 32'(w < 100), 32'd1);
        res_valid = 1'b1;
        res_num   = n;
        res_note  = nt;
        if (show) sb_q.push_back('{num: expn, note: nt});
        @(negedge clk_100);
        res_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_num"},   32'(num_to_display), 32'd0);
        chk({tag, "_note"},  32'(note),           32'd0);
        chk({tag, "_blank"}, 32'(disp_blank),     32'd1);
        chk({tag, "_upd"},   32'(upd_pulse),      32'd0);
        chk({tag, "_ready"}, 32'(res_ready),      32'd1);
    endtask

    initial begin
        int lowcnt;
        int e0;
        int w;
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_num   = 10'd0;
        res_note  = 3'd0;
        repeat (3) @(negedge clk_100);
        rst_n = 1'b1;
        @(negedge clk_100);
        chk_reset_outputs("reset");

        // First result: shown next cycle, ready low for exactly HOLD cycles.
        res_valid = 1'b1;
        res_num   = 10'd25;
        res_note  = 3'd0;
        sb_q.push_back('{num: 10'd25, note: 3'd0});
        @(negedge clk_100);
        res_valid = 1'b0;
        chk("first_num",   32'(num_to_display), 32'd25);
        chk("first_blank", 32'(disp_blank),     32'd0);
        chk("first_upd",   32'(upd_pulse),      32'd1);
        lowcnt = 0;
        while (res_ready === 1'b0 && lowcnt < 50) begin
            lowcnt++;
            @(negedge clk_100);
        end
        chk("ready_low_cycles", 32'(lowcnt), 32'(HOLD));

        // Continuous valid with a new value every cycle: accepts every HOLD+1 cycles.
        pulse_cyc.delete();
        for (int k = 0; k < 30; k++) begin
            res_valid = 1'b1;
            res_num   = 10'(100 + k);
            res_note  = 3'd3;
            if (k % (HOLD + 1) == 0) sb_q.push_back('{num: 10'(100 + k), note: 3'd3});
            @(negedge clk_100);
        end
        res_valid = 1'b0;
        repeat (2) @(negedge clk_100);
        chk("stream_pulse_count", 32'(pulse_cyc.size()), 32'd4);
        for (int i = 0; i + 1 < pulse_cyc.size(); i++) begin
            chk("stream_pulse_gap", 32'(pulse_cyc[i+1] - pulse_cyc[i]), 32'(HOLD + 1));
        end
        chk("stream_sb_drained", 32'(sb_q.size()), 32'd0);

        // Saturation, then an invalid note that must leave everything alone.
        send(10'd1023, 3'd2, 1'b1, 10'd999);
        chk("clamp_num", 32'(num_to_display), 32'd999);
        send(10'd55, 3'd7, 1'b0, 10'd0);
        chk("badnote_upd",   32'(upd_pulse),      32'd0);
        chk("badnote_num",   32'(num_to_display), 32'd999);
        chk("badnote_note",  32'(note),           32'd2);
        chk("badnote_ready", 32'(res_ready),      32'd1);

        // Silence timeout: blank exactly TMO edges after the last valid transfer.
        send(10'd300, 3'd4, 1'b1, 10'd300);
        e0 = cyc;
        w  = 0;
        while (disp_blank !== 1'b1 && w < 100) begin
            @(negedge clk_100);
            w++;
        end
        chk("timeout_edges", 32'(cyc - e0), 32'(TMO));
        chk("timeout_keep_num",  32'(num_to_display), 32'd300);
        chk("timeout_keep_note", 32'(note),           32'd4);
        chk("timeout_ready",     32'(res_ready),      32'd1);

        // Transfer on the timeout edge wins over blanking.
        send(10'd400, 3'd5, 1'b1, 10'd400);
        e0 = cyc;
        while (cyc < e0 + TMO - 1) @(negedge clk_100);
        res_valid = 1'b1;
        res_num   = 10'd410;
        res_note  = 3'd1;
        sb_q.push_back('{num: 10'd410, note: 3'd1});
        @(negedge clk_100);
        res_valid = 1'b0;
        chk("race_blank", 32'(disp_blank), 32'd0);
        chk("race_upd",   32'(upd_pulse),  32'd1);
        @(negedge clk_100);
        chk("race_blank_after", 32'(disp_blank), 32'd0);

        // Reset while holding, with a pending request on the bus.
        res_valid = 1'b1;
        res_num   = 10'd77;
        res_note  = 3'd2;
        rst_n     = 1'b0;
        @(negedge clk_100);
        res_valid = 1'b0;
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        @(negedge clk_100);

`ifdef DISP_NOTE_STABLE_EN
        send(10'd10, 3'd1, 1'b1, 10'd10);
        send(10'd5,  3'd2, 1'b0, 10'd0);
        chk("stab_first_note", 32'(note),           32'd1);
        chk("stab_first_num",  32'(num_to_display), 32'd10);
        send(10'd16, 3'd2, 1'b1, 10'd16);
        chk("stab_agree_note", 32'(note),           32'd2);
        chk("stab_agree_num",  32'(num_to_display), 32'd16);
        send(10'd7, 3'd3, 1'b0, 10'd0);
        send(10'd8, 3'd1, 1'b0, 10'd0);
        chk("stab_flip_note", 32'(note), 32'd2);
        send(10'd9, 3'd1, 1'b1, 10'd9);
        chk("stab_final_note", 32'(note),           32'd1);
        chk("stab_final_num",  32'(num_to_display), 32'd9);
`endif

        repeat (3) @(negedge clk_100);
        chk("sb_final_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_update_ctrl.md
# display_update_ctrl

Scheduler between the tuner's pitch-estimation result stream and the `display_result` seven-segment driver. It accepts results over a valid/ready handshake and enforces a minimum on-screen hold time so digits stay readable. It blanks the display when the input signal has been silent too long and clamps values to the displayable range. Its outputs drive `display_result`'s `num_to_display` and `note` inputs directly, plus a blank control.

## Interface
- `HOLD_CYCLES`, default 10_000_000: minimum clk_100 cycles a shown result stays before a new one is accepted (100 ms).
- `TIMEOUT_CYCLES`, default 200_000_000: cycles with no accepted result before blanking (2 s); must be > `HOLD_CYCLES`.
- `MAX_NUM`, default 999: saturation value for `num_to_display`.
- `clk_100`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `res_valid`  in  1  result available from estimator.
- `res_ready`  out  1  controller can accept a result this cycle.
- `res_num`  in  10  magnitude to display, unsigned.
- `res_note`  in  3  note index 0..5; 6 and 7 are invalid.
- `num_to_display`  out  10  registered value to the display driver.
- `note`  out  3  registered note index to the display driver.
- `disp_blank`  out  1  1 = display shows nothing.
- `upd_pulse`  out  1  one-cycle pulse when the outputs change to a new result.

## Operation
- Transfer: `res_valid && res_ready` sampled on a rising edge. `res_valid` may drop at any time without penalty; the controller never stalls the producer except in HOLD.
- States:
  - BLANK: reset state. `res_ready`=1, `disp_blank`=1. On transfer, go to HOLD.
  - HOLD: `res_ready`=0. Hold counter counts 0..`HOLD_CYCLES`-1. At terminal count, go to OPEN.
  - OPEN: `res_ready`=1. On transfer, go to HOLD. If the silence counter reaches `TIMEOUT_CYCLES`-1, go to BLANK.
- On every transfer, in any accepting state:
  - `num_to_display` <= min(`res_num`, `MAX_NUM`).
  - `note` <= `res_note`.
  - `disp_blank` <= 0.
  - `upd_pulse` = 1 for one cycle.
  - Hold counter and silence counter are cleared.
- Invalid note (6 or 7): the transfer completes, `res_ready` handshake included. The result is discarded, outputs and state are unchanged, and there is no `upd_pulse`.
- Silence counter runs in HOLD and OPEN and is cleared only by a valid transfer. It saturates and does not wrap.
- Timeout and transfer in the same cycle: the transfer wins, giving HOLD with the new data.
- Entry to BLANK: `disp_blank`=1. `num_to_display` and `note` keep their last values.

## Timing
- Reset values: `num_to_display`=0, `note`=0, `disp_blank`=1, `upd_pulse`=0, `res_ready`=1, state BLANK, both counters 0.
- Reset mid-operation returns to BLANK on the next edge, regardless of state or pending handshake.
- Latency: transfer at edge N gives new `num_to_display`/`note`/`disp_blank` and `upd_pulse`=1 after edge N, i.e. visible in cycle N+1.
- `res_ready` is a registered state decode. It falls in the cycle after a transfer and rises exactly `HOLD_CYCLES` cycles after the transfer edge.
- The minimum spacing between two `upd_pulse`s is `HOLD_CYCLES`+1 cycles.
- Blanking happens `TIMEOUT_CYCLES` cycles after the last valid transfer edge.

## Configuration
- `DISP_NOTE_STABLE_EN`
  - When defined: a result whose note differs from the currently shown `note` is shown only if the immediately preceding *accepted* result had that same new note (two consecutive agreements). Otherwise it is stored as a candidate, handshake completes, outputs are unchanged, no `upd_pulse`, and the hold and silence counters are still cleared. Same-note results update `num_to_display` immediately. From BLANK, the first valid result is shown directly.
  - When undefined: every valid result is shown immediately, and no candidate register exists.

## Test plan
Benches use `HOLD_CYCLES`=8, `TIMEOUT_CYCLES`=40.
- Reset, then drive `res_valid`=1, `res_num`=25, `res_note`=0 → next cycle `num_to_display`=25, `note`=0, `disp_blank`=0, `upd_pulse`=1; `res_ready`=0 for 8 cycles, then 1.
- Hold `res_valid` high with a new value each cycle → `upd_pulse` spacing exactly 9 cycles; values shown are those present on the accepting edges.
- `res_num`=1023 → `num_to_display`=999. `res_note`=7 → handshake completes, outputs unchanged, no pulse.
- Present one result, then go silent → `disp_blank`=1 after 40 cycles. Issue a new transfer on the timeout edge → no blank, new value shown.
- Assert `rst_n`=0 during HOLD → next cycle all outputs at reset values, `res_ready`=1.
- With `DISP_NOTE_STABLE_EN`: show note 1, send note 2 (num 5) → unchanged; send note 2 (num 16) → `note`=2, `num_to_display`=16. Send note 3 then note 1 → `note` stays 2 until the note-1 result updates `num`.
